instruction_fetch_unit: RTL

Sequencer in front of the program memory ROM. It owns the fetch program counter, drives the ROM address, and captures each returned instruction with its PC into a small in-order prefetch queue. It presents queued instructions to the decode stage through a valid/ready handshake, and it flushes and refetches when a branch or jump redirect arrives.

---
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives the program ROM address
// and captures each {pc, instruction} pair into an in-order prefetch queue.
// Queued instructions are offered to decode through a valid/ready handshake.
// A redirect flushes the queue and restarts fetching at the new address.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   fetch_enable                      permits new ROM reads
//   rom_address / rom_instruction     program memory read port (combinational data)
//   instr_valid/ready/data/pc         decode-side handshake and head entry
//   redirect_valid / redirect_pc      flush and restart request
//   fifo_count                        current queue occupancy
module instruction_fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  output logic [DATA_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [4:0]            fifo_count
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StStall} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [4:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr_q [FIFO_DEPTH];

  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] redirect_target;

  assign pop  = instr_valid & instr_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push = fetch_enable & ~redirect_valid & ((count_q < DepthCnt) | pop);

  // Low address bits are forced to zero so fetches stay word aligned.
  assign redirect_target = redirect_pc & ~DATA_WIDTH'(3);

  // Queue and PC next-state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // The same-cycle pop has already been handed to the consumer; the rest is dropped.
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_enable) begin
          state_d = (count_d == DepthCnt) ? StStall : StFetch;
        end
      end
      StFetch: begin
        if (!fetch_enable) begin
          state_d = StIdle;
        end else if (count_d == DepthCnt) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (!fetch_enable) begin
          state_d = StIdle;
        end else if (pop || redirect_valid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
      mem_instr_q[wr_ptr_q] <= rom_instruction;
    end
  end

  assign rom_address = fetch_pc_q;
  assign instr_valid = (count_q != 5'd0);
  assign instr_data  = mem_instr_q[rd_ptr_q];
  assign instr_pc    = mem_pc_q[rd_ptr_q];
  assign fifo_count  = count_q;

  // The stall state is only ever entered with a full queue and left before it drains.
  stall_full_a: assert property (@(posedge clk) disable iff (reset)
    (state_q == StStall) |-> (count_q == DepthCnt));

endmodule
